// File: rtl/mult_seq_ctrl.sv
// Sequential 6x4 unsigned multiplier built around an external 3x2 combinational
// multiplier: four partial products accumulated over four RUN cycles.
module mult_seq_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [5:0] a,
   input  logic [3:0] b,
   output logic       busy,
   output logic       done,
   output logic [9:0] product,
   output logic [2:0] mul_m,
   output logic [1:0] mul_p,
   input  logic [4:0] mul_s
);

   // state | meaning
   // IDLE  | waiting for start; product holds last result
   // RUN   | four accumulate steps, k selects operand slices
   // DONE  | one-cycle done pulse, product valid
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state, state_n;
   logic [1:0]  k, k_n;
   logic [5:0]  a_lat, a_lat_n;
   logic [3:0]  b_lat, b_lat_n;
   logic [9:0]  acc, acc_n;
   logic [2:0]  shamt;
   logic [9:0]  pp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         k     <= 2'd0;
         a_lat <= 6'd0;
         b_lat <= 4'd0;
         acc   <= 10'd0;
      end else begin
         state <= state_n;
         k     <= k_n;
         a_lat <= a_lat_n;
         b_lat <= b_lat_n;
         acc   <= acc_n;
      end
   end

   always_comb begin
      state_n = state;
      k_n     = k;
      a_lat_n = a_lat;
      b_lat_n = b_lat;
      acc_n   = acc;
      busy    = 1'b0;
      done    = 1'b0;
      mul_m   = 3'd0;
      mul_p   = 2'd0;
      // slice weights: a[5:3] is worth 2^3, b[3:2] is worth 2^2
      shamt   = (k[1] ? 3'd3 : 3'd0) + (k[0] ? 3'd2 : 3'd0);
      pp      = {5'd0, mul_s} << shamt;
      case (state)
         IDLE: begin
            if (start) begin
               a_lat_n = a;
               b_lat_n = b;
               acc_n   = 10'd0;
               k_n     = 2'd0;
               state_n = RUN;
            end
         end
         RUN: begin
            busy    = 1'b1;
            mul_m   = k[1] ? a_lat[5:3] : a_lat[2:0];
            mul_p   = k[0] ? b_lat[3:2] : b_lat[1:0];
            acc_n   = acc + pp;
            k_n     = k + 2'd1;
            if (k == 2'd3) state_n = DONE;
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign product = acc;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: cycle-level reference model plus literal
// expectations for the named scenarios and an exhaustive operand sweep.
module tb_mult_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [5:0] a;
   logic [3:0] b;
   logic       busy, done;
   logic [9:0] product;
   logic [2:0] mul_m;
   logic [1:0] mul_p;
   logic [4:0] mul_s;

   int n_checks = 0;
   int n_fail   = 0;

   mult_seq_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .product(product),
      .mul_m(mul_m), .mul_p(mul_p), .mul_s(mul_s)
   );

   // external 3x2 combinational multiplier
   assign mul_s = 5'(mul_m) * 5'(mul_p);

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: phase 0 idle, 1..4 run steps, 5 done
   int         m_phase = 0;
   logic [5:0] m_a = 6'd0;
   logic [3:0] m_b = 4'd0;
   int         m_prod = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0;
         m_a     = 6'd0;
         m_b     = 4'd0;
         m_prod  = 0;
      end else if (m_phase == 0) begin
         if (start) begin
            m_phase = 1;
            m_a     = a;
            m_b     = b;
         end
      end else if (m_phase == 4) begin
         m_phase = 5;
         m_prod  = int'(m_a) * int'(m_b);
      end else if (m_phase == 5) begin
         m_phase = 0;
      end else begin
         m_phase = m_phase + 1;
      end
   end

   int done_cnt = 0;
   int busy_cnt = 0;
   int last_done_prod = -1;

   always @(negedge clk) begin
      int j;
      int exp_m, exp_p;
      if (rst) begin
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_product", product, 0);
         chk("rst_mul_m", mul_m, 0);
         chk("rst_mul_p", mul_p, 0);
      end else begin
         chk("busy", busy, (m_phase != 0) ? 1 : 0);
         chk("done", done, (m_phase == 5) ? 1 : 0);
         exp_m = 0;
         exp_p = 0;
         if (m_phase >= 1 && m_phase <= 4) begin
            j = m_phase - 1;
            exp_m = (j >= 2) ? int'(m_a[5:3]) : int'(m_a[2:0]);
            exp_p = (j % 2 == 1) ? int'(m_b[3:2]) : int'(m_b[1:0]);
         end
         chk("mul_m", mul_m, exp_m);
         chk("mul_p", mul_p, exp_p);
         if (m_phase == 0 || m_phase == 5) chk("product", product, m_prod);
         if (done) begin
            done_cnt++;
            last_done_prod = int'(product);
         end
         if (busy) busy_cnt++;
      end
   end

   task automatic do_op(input logic [5:0] ta, input logic [3:0] tb_, input int exp_prod);
      int d0;
      d0 = done_cnt;
      @(negedge clk);
      start = 1'b1; a = ta; b = tb_;
      @(negedge clk);
      start = 1'b0; a = ~ta; b = ~tb_;
      repeat (5) @(negedge clk);
      chk("op_done_count", done_cnt - d0, 1);
      chk("op_product", last_done_prod, exp_prod);
   endtask

   initial begin
      int d0;
      rst = 1'b1; start = 1'b0; a = 6'd0; b = 4'd0;
      repeat (2) @(negedge clk);
      chk("reset_product", product, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      #2 rst = 1'b0;

      // a=45, b=11
      busy_cnt = 0;
      do_op(6'd45, 4'd11, 495);
      chk("busy_cycles_45x11", busy_cnt, 5);
      chk("product_held_45x11", product, 495);

      do_op(6'd63, 4'd15, 945);
      do_op(6'd0,  4'd9,  0);
      do_op(6'd7,  4'd1,  7);

      // second start during RUN is ignored
      d0 = done_cnt;
      @(negedge clk); start = 1'b1; a = 6'd10; b = 4'd3;
      @(negedge clk); start = 1'b0; a = 6'd33;
      @(negedge clk); start = 1'b1; a = 6'd20; b = 4'd5;
      @(negedge clk); start = 1'b0;
      repeat (10) @(negedge clk);
      chk("ignore_start_done_count", done_cnt - d0, 1);
      chk("ignore_start_product", last_done_prod, 30);

      // start held high: back-to-back ops every 6 cycles
      d0 = done_cnt;
      @(negedge clk); start = 1'b1; a = 6'd5; b = 4'd5;
      repeat (7) @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      chk("held_start_done_count", done_cnt - d0, 2);
      chk("held_start_product", last_done_prod, 25);

      // reset in the middle of RUN
      d0 = done_cnt;
      @(negedge clk); start = 1'b1; a = 6'd45; b = 4'd11;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrun_rst_busy", busy, 0);
      chk("midrun_rst_product", product, 0);
      chk("midrun_rst_mul_m", mul_m, 0);
      chk("midrun_rst_mul_p", mul_p, 0);
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (8) @(negedge clk);
      chk("midrun_rst_no_done", done_cnt - d0, 0);
      do_op(6'd3, 4'd2, 6);

      // exhaustive sweep
      for (int ai = 0; ai < 64; ai++)
         for (int bi = 0; bi < 16; bi++)
            do_op(ai[5:0], bi[3:0], ai * bi);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
